// File: rtl/dec2ex_stall_ctrl.sv
// Decode-to-execute stall control: sequences iterative mul/div ops and derives the dec2ex register-group load enables.
// Optional feature macro: MULDIV_EARLY_OUT_EN (md_early finishes a busy operation on the next cycle).
module dec2ex_stall_ctrl #(
   parameter int W = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dec_stall,
   input  logic       stall_mmu,
   input  logic       trap,
   input  logic       md_start,
   input  logic       md_is_div,
   input  logic       md_early,
   output logic [5:0] grp_en,
   output logic       md_busy,
   output logic       md_done,
   output logic       md_abort,
   output logic [5:0] md_cnt
);

   localparam logic [5:0] MUL_CNT = 6'(W / 2 - 1);
   localparam logic [5:0] DIV_CNT = 6'(W - 1);
`ifdef MULDIV_EARLY_OUT_EN
   localparam logic EARLY_EN = 1'b1;
`else
   localparam logic EARLY_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [5:0] r_cnt;
   logic [5:0] w_cnt_nxt;
   logic       r_busy;
   logic       r_done;
   logic       r_abort;
   logic       w_abort_nxt;
   logic [5:0] w_reload;
   logic       w_busy_eff;
   logic       w_hold;

   assign w_reload = md_is_div ? DIV_CNT : MUL_CNT;

   // Next-state and next-count logic; trap always takes priority over start/completion
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_abort_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (md_start && !trap) begin
               w_state_nxt = BUSY;
               w_cnt_nxt   = w_reload;
            end else begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = 6'd0;
            end
         end
         BUSY: begin
            if (trap) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = 6'd0;
               w_abort_nxt = 1'b1;
            end else if (r_cnt == 6'd0 || (EARLY_EN && md_early)) begin
               w_state_nxt = DONE;
               w_cnt_nxt   = 6'd0;
            end else begin
               w_state_nxt = BUSY;
               w_cnt_nxt   = r_cnt - 6'd1;
            end
         end
         DONE: begin
            if (trap) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = 6'd0;
               w_abort_nxt = 1'b1;
            end else if (md_start) begin
               w_state_nxt = BUSY;
               w_cnt_nxt   = w_reload;
            end else begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = 6'd0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 6'd0;
         end
      endcase
   end

   // State, counter and status flags; flags follow the next state so they align with it
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= 6'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_abort <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_state_nxt == BUSY);
         r_done  <= (w_state_nxt == DONE);
         r_abort <= w_abort_nxt;
      end
   end

   // While reset is held the enables must look as if the FSM were already idle
   assign w_busy_eff = reset ? 1'b0 : r_busy;
   assign w_hold     = dec_stall | w_busy_eff;

   assign grp_en[0] = ~w_hold;
   assign grp_en[1] = ~w_hold | w_busy_eff;
   assign grp_en[2] = w_busy_eff;
   assign grp_en[3] = ~w_hold | trap;
   assign grp_en[4] = 1'b1;
   assign grp_en[5] = ~dec_stall | stall_mmu;

   assign md_busy  = r_busy;
   assign md_done  = r_done;
   assign md_abort = r_abort;
   assign md_cnt   = r_cnt;

endmodule

// File: tb/tb_dec2ex_stall_ctrl.sv
// Directed bench for dec2ex_stall_ctrl (W=32); expectations are hand-derived constants.
module tb_dec2ex_stall_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       dec_stall;
   logic       stall_mmu;
   logic       trap;
   logic       md_start;
   logic       md_is_div;
   logic       md_early;
   logic [5:0] grp_en;
   logic       md_busy;
   logic       md_done;
   logic       md_abort;
   logic [5:0] md_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   dec2ex_stall_ctrl #(.W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .dec_stall (dec_stall),
      .stall_mmu (stall_mmu),
      .trap      (trap),
      .md_start  (md_start),
      .md_is_div (md_is_div),
      .md_early  (md_early),
      .grp_en    (grp_en),
      .md_busy   (md_busy),
      .md_done   (md_done),
      .md_abort  (md_abort),
      .md_cnt    (md_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks busy/done/abort/cnt together
   task automatic check_st(input string tag, input logic b, input logic d, input logic a,
                           input logic [5:0] c);
      check({tag, ".busy"},  {31'd0, md_busy},  {31'd0, b});
      check({tag, ".done"},  {31'd0, md_done},  {31'd0, d});
      check({tag, ".abort"}, {31'd0, md_abort}, {31'd0, a});
      check({tag, ".cnt"},   {26'd0, md_cnt},   {26'd0, c});
   endtask

   initial begin
      reset = 1'b1; dec_stall = 1'b0; stall_mmu = 1'b0; trap = 1'b0;
      md_start = 1'b0; md_is_div = 1'b0; md_early = 1'b0;
      tick(); tick();
      check_st("reset", 1'b0, 1'b0, 1'b0, 6'd0);
      check("reset.grp_en", {26'd0, grp_en}, {26'd0, 6'b111011});
      // Start requested while reset is held must not launch an operation
      md_start = 1'b1;
      tick();
      check_st("reset_start", 1'b0, 1'b0, 1'b0, 6'd0);
      check("reset_start.grp_en", {26'd0, grp_en}, {26'd0, 6'b111011});
      reset = 1'b0; md_start = 1'b0;
      tick();
      check_st("idle", 1'b0, 1'b0, 1'b0, 6'd0);

      // Multiply: 16 busy cycles, then a single done cycle
      md_start = 1'b1; md_is_div = 1'b0;
      tick();
      md_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check_st($sformatf("mul_busy%0d", i), 1'b1, 1'b0, 1'b0, 6'(15 - i));
         check($sformatf("mul_grp%0d", i), {26'd0, grp_en}, {26'd0, 6'b110110});
         tick();
      end
      check_st("mul_done", 1'b0, 1'b1, 1'b0, 6'd0);
      check("mul_done.grp_en", {26'd0, grp_en}, {26'd0, 6'b111011});
      tick();
      check_st("mul_idle", 1'b0, 1'b0, 1'b0, 6'd0);

      // Divide with start held high throughout: 32 busy cycles, then back-to-back multiply
      md_start = 1'b1; md_is_div = 1'b1;
      tick();
      for (int i = 0; i < 32; i++) begin
         check_st($sformatf("div_busy%0d", i), 1'b1, 1'b0, 1'b0, 6'(31 - i));
         check($sformatf("div_grp0_%0d", i), {31'd0, grp_en[0]}, 32'd0);
         tick();
      end
      check_st("div_done", 1'b0, 1'b1, 1'b0, 6'd0);
      md_is_div = 1'b0;
      tick();
      md_start = 1'b0;
      check_st("b2b_reload", 1'b1, 1'b0, 1'b0, 6'd15);

      // Trap at busy cycle 5
      tick(); tick(); tick(); tick();
      check_st("pre_trap", 1'b1, 1'b0, 1'b0, 6'd11);
      trap = 1'b1;
      #1;
      check("trap.grp_en", {26'd0, grp_en}, {26'd0, 6'b111110});
      tick();
      trap = 1'b0;
      check_st("trap_abort", 1'b0, 1'b0, 1'b1, 6'd0);
      tick();
      check_st("trap_after", 1'b0, 1'b0, 1'b0, 6'd0);

      // Trap and start together in IDLE: trap wins
      md_start = 1'b1; trap = 1'b1;
      tick();
      md_start = 1'b0; trap = 1'b0;
      check_st("idle_trap_start", 1'b0, 1'b0, 1'b0, 6'd0);

      // Stall-only enables
      dec_stall = 1'b1; stall_mmu = 1'b0;
      #1;
      check("stall.grp_en", {26'd0, grp_en}, {26'd0, 6'b010000});
      stall_mmu = 1'b1;
      #1;
      check("stall_mmu.grp_en", {26'd0, grp_en}, {26'd0, 6'b110000});
      dec_stall = 1'b0; stall_mmu = 1'b0;

      // Trap arriving in DONE (with start high) aborts and returns to IDLE
      md_start = 1'b1; md_is_div = 1'b0;
      tick();
      md_start = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      check_st("done_pre_trap", 1'b0, 1'b1, 1'b0, 6'd0);
      trap = 1'b1; md_start = 1'b1;
      tick();
      trap = 1'b0; md_start = 1'b0;
      check_st("done_trap", 1'b0, 1'b0, 1'b1, 6'd0);
      tick();

      // Reset mid-operation: no abort pulse
      md_start = 1'b1; md_is_div = 1'b1;
      tick();
      md_start = 1'b0;
      tick(); tick();
      check_st("pre_reset", 1'b1, 1'b0, 1'b0, 6'd29);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_st("mid_reset", 1'b0, 1'b0, 1'b0, 6'd0);
      tick();

      // Early-out request at busy cycle 3 of a divide
      md_start = 1'b1; md_is_div = 1'b1;
      tick();
      md_start = 1'b0;
      tick(); tick();
      check_st("early_pre", 1'b1, 1'b0, 1'b0, 6'd29);
      md_early = 1'b1;
      tick();
`ifdef MULDIV_EARLY_OUT_EN
      check_st("early_done", 1'b0, 1'b1, 1'b0, 6'd0);
`else
      for (int i = 28; i >= 0; i--) begin
         check_st($sformatf("early_ign%0d", i), 1'b1, 1'b0, 1'b0, 6'(i));
         tick();
      end
      check_st("early_full_done", 1'b0, 1'b1, 1'b0, 6'd0);
`endif
      md_early = 1'b0;
      tick();
      check_st("final_idle", 1'b0, 1'b0, 1'b0, 6'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dec2ex_stall_ctrl.md
DEC2EX_STALL_CTRL -- requirements
Module: dec2ex_stall_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning datapath width; it sets the multiply/divide iteration counts.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port dec_stall, input, 1 bit: the decode stage requests a hold.
REQ-005 The block SHALL have port stall_mmu, input, 1 bit: the memory unit requests a hold.
REQ-006 The block SHALL have port trap, input, 1 bit: a trap or exception is taken this cycle.
REQ-007 The block SHALL have port md_start, input, 1 bit: decode presents a mul/div instruction.
REQ-008 The block SHALL have port md_is_div, input, 1 bit: 1 selects divide, 0 selects multiply; sampled together with md_start.
REQ-009 The block SHALL have port md_early, input, 1 bit: the datapath reports a trivial operand (zero multiplier or zero divisor).
REQ-010 The block SHALL have port grp_en, output, 6 bits: bit k is the load enable for dec2ex register group k+1.
REQ-011 The block SHALL have port md_busy, output, 1 bit: an iterative mul/div operation is in progress.
REQ-012 The block SHALL have port md_done, output, 1 bit: a one-cycle pulse on completion.
REQ-013 The block SHALL have port md_abort, output, 1 bit: a one-cycle pulse when a trap kills an operation.
REQ-014 The block SHALL have port md_cnt, output, 6 bits: remaining iterations.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-016 In IDLE, when md_start=1 and trap=0, the FSM SHALL move to BUSY and load md_cnt with W/2-1 for multiply or W-1 for divide.
REQ-017 In BUSY, md_cnt SHALL decrement by 1 each cycle; in the cycle md_cnt=0, the FSM SHALL move to DONE.
REQ-018 In DONE, md_done SHALL be 1 for exactly that cycle; the FSM SHALL then move to BUSY if md_start=1 and trap=0 (reloading md_cnt), else to IDLE.
REQ-019 When trap=1 in BUSY or DONE, the FSM SHALL move to IDLE next cycle, md_abort SHALL pulse that same cycle, md_done SHALL be suppressed, and md_cnt SHALL be cleared to 0.
REQ-020 md_busy SHALL be 1 exactly when the state is BUSY.
REQ-021 The internal hold term SHALL be computed as hold = dec_stall | md_busy.
REQ-022 grp_en[0] SHALL equal ~hold.
REQ-023 grp_en[1] SHALL equal ~hold | md_busy.
REQ-024 grp_en[2] SHALL equal md_busy.
REQ-025 grp_en[3] SHALL equal ~hold | trap.
REQ-026 grp_en[4] SHALL equal 1.
REQ-027 grp_en[5] SHALL equal ~dec_stall | stall_mmu.
REQ-028 grp_en SHALL be combinational from the current state and inputs, with zero-cycle latency; all other outputs SHALL be registered.
REQ-029 md_start SHALL be ignored while in BUSY; no queueing.
REQ-030 When trap and md_start are asserted together in IDLE, trap SHALL win: the FSM stays in IDLE and no pulse is produced.
REQ-031 md_cnt SHALL never wrap below 0.

Reset
REQ-032 When reset=1 at a clock edge, the state SHALL become IDLE, md_cnt=0, md_busy=0, md_done=0 and md_abort=0.
REQ-033 A reset asserted mid-operation SHALL abort the operation without an md_abort pulse.
REQ-034 During reset, grp_en SHALL evaluate from the IDLE state and the live inputs.

Configuration
REQ-035 With macro MULDIV_EARLY_OUT_EN defined, md_early=1 in BUSY SHALL force a transition to DONE next cycle, with md_cnt cleared to 0.
REQ-036 With MULDIV_EARLY_OUT_EN undefined, md_early SHALL be ignored and every operation SHALL run its full iteration count.

Verification
REQ-037 Reset, then md_start=1, md_is_div=0, W=32 -> md_busy=1 for 16 cycles, md_done pulses once in cycle 17, grp_en[2]=1 only while busy.
REQ-038 Divide with no trap -> md_cnt counts 31 down to 0, md_done pulses after 32 busy cycles, grp_en[0]=0 throughout busy.
REQ-039 Trap at busy cycle 5 -> md_abort pulse, IDLE next cycle, md_cnt=0, no md_done, grp_en[3]=1 in the trap cycle.
REQ-040 md_start held high across DONE -> md_done pulse, then BUSY immediately with md_cnt reloaded to 15 (multiply) or 31 (divide).
REQ-041 dec_stall=1, stall_mmu=0 -> grp_en=6'b010000; then stall_mmu=1 -> grp_en=6'b110000.
REQ-042 With MULDIV_EARLY_OUT_EN defined, md_early=1 at busy cycle 3 -> DONE next cycle, md_done pulses; with the macro undefined, the full 32 cycles elapse.
